uart_tx_ctrl: RTL

Frame controller for the UART transmit path. It accepts a parallel byte handshake, sequences the companion serializer (drives ser_en, consumes ser_data/ser_done), and generates start, optional parity, and stop bits. It drives the registered, idle-high serial line TX_OUT. It sits between the TX data source (e.g. FIFO or register file) and the UART pin.

---
 rtl/uart_tx_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//   Frame controller for the UART transmit path. Accepts a byte request,
//   sequences the companion serializer and frames its bit stream with a start
//   bit, an optional parity bit and STOP_BITS stop bits on the registered,
//   idle-high serial line TX_OUT.
//
// Parameters
//   Data_WD    data bits per frame (must match the serializer)
//   STOP_BITS  stop bits per frame (1 or 2)
//
// Ports
//   CLK         system clock, rising edge
//   RST         asynchronous active-low reset
//   P_DATA      parallel data, used only to compute parity at acceptance
//   Data_Valid  single-cycle request, accepted only while busy=0
//   PAR_EN      1 = append parity bit (sampled at acceptance)
//   PAR_TYP     0 = even, 1 = odd parity (sampled at acceptance)
//   ser_done    serializer has shifted out all data bits
//   ser_data    serializer registered bit output
//   ser_en      serializer enable (high in START and DATA)
//   TX_OUT      registered serial line, idle high
//   busy        frame in progress (state != IDLE)
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int Data_WD   = 8,
    parameter int STOP_BITS = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [Data_WD-1:0] P_DATA,
    input  logic               Data_Valid,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic               ser_done,
    input  logic               ser_data,
    output logic               ser_en,
    output logic               TX_OUT,
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_par_bit;
    logic       r_par_en;
    logic [1:0] r_stop_cnt;
    logic       r_tx;
    logic       w_tx_nxt;
    logic       w_accept;

    assign w_accept = (r_state == IDLE) && Data_Valid;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame configuration is captured once at acceptance so later changes
    // on the inputs cannot disturb a frame already in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_bit <= 1'b0;
            r_par_en  <= 1'b0;
        end else if (w_accept) begin
            r_par_bit <= (^P_DATA) ^ PAR_TYP;
            r_par_en  <= PAR_EN;
        end
    end

    // Held at zero outside STOP, so it is always clear on entry.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_stop_cnt <= '0;
        end else if (r_state == STOP) begin
            r_stop_cnt <= r_stop_cnt + 2'd1;
        end else begin
            r_stop_cnt <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_tx <= 1'b1;
        end else begin
            r_tx <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = 1'b1;
        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (Data_Valid) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                w_tx_nxt    = 1'b0;
                w_state_nxt = DATA;
            end
            DATA: begin
                // ser_data already lags the serializer count by one cycle;
                // the START cycle absorbs that lag, so it is passed straight through.
                w_tx_nxt = ser_data;
                if (ser_done) begin
                    w_state_nxt = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                w_tx_nxt    = r_par_bit;
                w_state_nxt = STOP;
            end
            STOP: begin
                w_tx_nxt = 1'b1;
                if (r_stop_cnt == STOP_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ser_en = (r_state == START) || (r_state == DATA);
    assign busy   = (r_state != IDLE);
    assign TX_OUT = r_tx;

endmodule
